// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the BCD-to-binary converter: request word in, binary result out.
// Master drives the request and consumes the result; slave is the converter.
interface bcd_to_bin_if #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   din;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      dout;
    logic                  err;

    modport master (
        output in_valid, din, out_ready,
        input  in_ready, out_valid, dout, err
    );

    modport slave (
        input  in_valid, din, out_ready,
        output in_ready, out_valid, dout, err
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Packed-BCD to unsigned binary converter, reverse double-dabble, one iteration per cycle.
// Latency: accept edge + OUT_W shift edges (illegal nibble: result after the accept edge).
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    bcd_to_bin_if.slave   bus
);
    localparam int              CNT_W = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [4*DIGITS-1:0] r_bcd;
    logic [OUT_W-1:0]    r_bin;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_dout;
    logic                r_err;

    logic                w_illegal;
    logic [4*DIGITS-1:0] w_bcd_sh;
    logic [4*DIGITS-1:0] w_bcd_adj;
    logic [OUT_W-1:0]    w_bin_sh;

    always_comb begin
        w_illegal = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bus.din[4*d +: 4] > 4'd9) begin
                w_illegal = 1'b1;
            end
        end
    end

    // Per-digit correction is confined to each nibble; no borrow crosses digits.
    always_comb begin
        {w_bcd_sh, w_bin_sh} = {r_bcd, r_bin} >> 1;
        w_bcd_adj = w_bcd_sh;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_bcd_sh[4*d +: 4] >= 4'd8) begin
                w_bcd_adj[4*d +: 4] = w_bcd_sh[4*d +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (w_illegal) begin
                            r_dout  <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_bcd   <= bus.din;
                            r_bin   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_sh;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_dout  <= w_bin_sh;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.dout      = r_dout;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: hand-computed vectors plus a strided sweep against a bin-to-BCD model.
module tb_bcd_to_bin;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    bcd_to_bin_if #(.DIGITS(4), .OUT_W(14)) bus ();

    bcd_to_bin #(.DIGITS(4), .OUT_W(14)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        b[3:0]   = 4'(v % 10);
        b[7:4]   = 4'((v / 10) % 10);
        b[11:8]  = 4'((v / 100) % 10);
        b[15:12] = 4'((v / 1000) % 10);
        return b;
    endfunction

    // One transaction: offer din for one cycle, wait for the result, check it, consume it.
    task automatic run(input string tag, input logic [15:0] d, input int exp_dout,
                       input logic exp_err, input int exp_lat);
        int lat;
        bus.din      = d;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_dout"}, 32'(bus.dout), 32'(exp_dout));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_vld_fall"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int  lat;
        int  bad;
        logic [13:0] held;
        n_vec = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Max value: in_ready must stay low throughout the conversion.
        bus.din      = 16'h9999;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bad = 0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            if (bus.in_ready) bad++;
            tick();
            lat++;
        end
        chk("max_ready_low", 32'(bad + int'(bus.in_ready)), 32'd0);
        chk("max_lat", 32'(lat), 32'd15);
        chk("max_dout", 32'(bus.dout), 32'h270F);
        chk("max_err", 32'(bus.err), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("max_vld_fall", 32'(bus.out_valid), 32'd0);

        run("zero", 16'h0000, 0, 1'b0, 15);
        run("v31", 16'h0031, 31, 1'b0, 15);
        run("v1000", 16'h1000, 1000, 1'b0, 15);
        run("v8888", 16'h8888, 8888, 1'b0, 15);
        run("illegal_mid", 16'h12A4, 0, 1'b1, 1);
        run("illegal_top", 16'hF000, 0, 1'b1, 1);
        run("err_clears", 16'h0507, 507, 1'b0, 15);

        // Consumer stalls for 20 cycles; result and ready must hold.
        bus.din      = 16'h4321;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        held = bus.dout;
        chk("stall_dout", 32'(held), 32'd4321);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.out_valid || bus.in_ready || bus.dout !== 14'd4321) bad++;
        end
        chk("stall_hold", 32'(bad), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("stall_release_vld", 32'(bus.out_valid), 32'd0);
        chk("stall_release_rdy", 32'(bus.in_ready), 32'd1);

        // in_valid held with changing din while busy must not disturb the accepted word.
        bus.din      = 16'h1234;
        bus.in_valid = 1'b1;
        tick();
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            bus.din = 16'($urandom);
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("busy_ign_lat", 32'(lat), 32'd15);
        chk("busy_ign_dout", 32'(bus.dout), 32'd1234);
        chk("busy_ign_err", 32'(bus.err), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset at SHIFT iteration 7 discards the conversion at once.
        bus.din      = 16'h5678;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
        run("after_rst", 16'h0042, 42, 1'b0, 15);

        for (int v = 0; v < 10000; v += 37) begin
            run($sformatf("sweep%0d", v), to_bcd(v), v, 1'b0, 15);
        end
        run("sweep9999", to_bcd(9999), 9999, 1'b0, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
